// File: rtl/forward_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// forward_scoreboard_pkg
// Shared definitions for the operand-forwarding scoreboard:
//   - RV32 major opcode constants used by the decode stage
//   - slot_t : one in-flight register write {v, rd, we, late}
//   - dec_t  : per-opcode operand usage, write/late flags and ALU source selects
//   - decode_opcode() : opcode -> dec_t
//   - sel_width()     : width of a forward select for a given number of slots
// -----------------------------------------------------------------------------
package forward_scoreboard_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // One tracked register write. late = result only available from a later stage.
   typedef struct packed {
      logic       v;
      logic [4:0] rd;
      logic       we;
      logic       late;
   } slot_t;

   typedef struct packed {
      logic uses_rs1;
      logic uses_rs2;
      logic we;
      logic late;
      logic sel_a;
      logic sel_b;
   } dec_t;

   // Field order: {uses_rs1, uses_rs2, we, late, sel_a, sel_b}.
   // we here is the opcode-level write flag; rd == x0 is masked by the caller.
   function automatic dec_t decode_opcode(input logic [6:0] opcode);
      dec_t d;
      case (opcode)
         OPC_LUI:    d = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         OPC_AUIPC:  d = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
         OPC_JAL:    d = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
         OPC_JALR:   d = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         OPC_BRANCH: d = {1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
         OPC_LOAD:   d = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         OPC_STORE:  d = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
         OPC_OPIMM:  d = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
         OPC_OP:     d = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
         OPC_SYSTEM: d = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
         // Unknown opcodes neither read nor write, so they never stall or forward.
         default:    d = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      endcase
      return d;
   endfunction

   // Select value 0 means "register file", 1..num_stages name a slot.
   function automatic int sel_width(input int num_stages);
      return $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/forward_scoreboard_fwd_match.sv
// -----------------------------------------------------------------------------
// forward_scoreboard_fwd_match
// Priority match of one source operand against every tracked slot.
// Ports:
//   slots    in  NUM_STAGES x slot_t  slot contents, index 0 = slot 1 (youngest)
//   used     in  1     the decoding instruction actually reads this operand
//   reg_idx  in  5     source register number
//   hit      out 1     some valid writing slot targets reg_idx (never for x0)
//   slot_idx out SELW  1-based number of the youngest matching slot
//   ready    out 1     the matching slot's result can be forwarded this cycle
// -----------------------------------------------------------------------------
module forward_scoreboard_fwd_match
   import forward_scoreboard_pkg::*;
#(
   parameter int NUM_STAGES  = 2,
   parameter int READY_STAGE = 2,
   parameter int SELW        = 2
) (
   input  slot_t [NUM_STAGES-1:0] slots,
   input  logic                   used,
   input  logic [4:0]             reg_idx,
   output logic                   hit,
   output logic [SELW-1:0]        slot_idx,
   output logic                   ready
);

   // Scan oldest to youngest so that the youngest match is the one left standing.
   always_comb begin
      hit      = 1'b0;
      slot_idx = '0;
      ready    = 1'b1;
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (used && (reg_idx != 5'd0) && slots[k-1].v && slots[k-1].we &&
             (slots[k-1].rd == reg_idx)) begin
            hit      = 1'b1;
            slot_idx = SELW'(k);
            ready    = !(slots[k-1].late && (k < READY_STAGE));
         end else begin
            hit      = hit;
            slot_idx = slot_idx;
            ready    = ready;
         end
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// -----------------------------------------------------------------------------
// forward_scoreboard
// Operand-forwarding and load-use hazard unit for the decode stage. Every
// in-flight register write is tracked in a shift register with one slot per
// downstream stage (slot 1 youngest, slot NUM_STAGES performs the RF write).
// Ports:
//   clk, reset           clock (rising edge), asynchronous active-high reset
//   id_valid             decode holds a real instruction
//   id_opcode/rs1/rs2/rd decode instruction fields
//   flush                kill the decode instruction (it never enters slot 1)
//   stall                hold decode/fetch this cycle (combinational)
//   fwd_sel_rs1/rs2      0 = RF, k = forward from slot k (combinational)
//   sel_a                1 = PC to ALU A
//   sel_b                1 = immediate to ALU B
// -----------------------------------------------------------------------------
module forward_scoreboard
   import forward_scoreboard_pkg::*;
#(
   parameter  int NUM_STAGES  = 2,
   parameter  int READY_STAGE = 2,
   parameter  int RF_BYPASS   = 0,
   localparam int SELW        = sel_width(NUM_STAGES)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            id_valid,
   input  logic [6:0]      id_opcode,
   input  logic [4:0]      id_rs1,
   input  logic [4:0]      id_rs2,
   input  logic [4:0]      id_rd,
   input  logic            flush,
   output logic            stall,
   output logic [SELW-1:0] fwd_sel_rs1,
   output logic [SELW-1:0] fwd_sel_rs2,
   output logic            sel_a,
   output logic            sel_b
);

   slot_t [NUM_STAGES-1:0] slots_r;
   dec_t                   dec_s;
   logic                   we_s;
   logic                   issue_s;
   logic                   hit1_s, rdy1_s, hit2_s, rdy2_s;
   logic [SELW-1:0]        idx1_s, idx2_s;

   // Decode the instruction in the decode stage; a write to x0 is never tracked.
   always_comb begin
      dec_s = decode_opcode(id_opcode);
      we_s  = dec_s.we && (id_rd != 5'd0);
      sel_a = dec_s.sel_a;
      sel_b = dec_s.sel_b;
   end

   forward_scoreboard_fwd_match #(
      .NUM_STAGES  (NUM_STAGES),
      .READY_STAGE (READY_STAGE),
      .SELW        (SELW)
   ) u_match_rs1 (
      .slots    (slots_r),
      .used     (dec_s.uses_rs1),
      .reg_idx  (id_rs1),
      .hit      (hit1_s),
      .slot_idx (idx1_s),
      .ready    (rdy1_s)
   );

   forward_scoreboard_fwd_match #(
      .NUM_STAGES  (NUM_STAGES),
      .READY_STAGE (READY_STAGE),
      .SELW        (SELW)
   ) u_match_rs2 (
      .slots    (slots_r),
      .used     (dec_s.uses_rs2),
      .reg_idx  (id_rs2),
      .hit      (hit2_s),
      .slot_idx (idx2_s),
      .ready    (rdy2_s)
   );

   // Hazard and forward-select resolution. A not-ready match stalls and selects
   // the RF; with a write-through RF the oldest slot is read through the RF too.
   always_comb begin
      stall = id_valid && !flush && ((hit1_s && !rdy1_s) || (hit2_s && !rdy2_s));

      if (hit1_s && rdy1_s && !((RF_BYPASS != 0) && (idx1_s == SELW'(NUM_STAGES)))) begin
         fwd_sel_rs1 = idx1_s;
      end else begin
         fwd_sel_rs1 = '0;
      end

      if (hit2_s && rdy2_s && !((RF_BYPASS != 0) && (idx2_s == SELW'(NUM_STAGES)))) begin
         fwd_sel_rs2 = idx2_s;
      end else begin
         fwd_sel_rs2 = '0;
      end

      issue_s = id_valid && !stall && !flush;
   end

   // Slot shift register: older slots always advance (they are committed);
   // slot 1 takes the decode instruction or a bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slots_r <= '0;
      end else begin
         slots_r[0] <= {issue_s, id_rd, we_s, dec_s.late};
         for (int k = 1; k < NUM_STAGES; k++) begin
            slots_r[k] <= slots_r[k-1];
         end
      end
   end

endmodule

// File: tb/tb_forward_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_forward_scoreboard
// Drives two scoreboards in lockstep: defaults (2 stages, no bypass) and
// 3 stages with a write-through RF. A history model indexed by issue cycle
// predicts every output each cycle; literal expectations pin key scenarios.
// -----------------------------------------------------------------------------
module tb_forward_scoreboard;
   import forward_scoreboard_pkg::*;

   logic       clk       = 1'b0;
   logic       reset     = 1'b1;
   logic       id_valid  = 1'b0;
   logic [6:0] id_opcode = 7'd0;
   logic [4:0] id_rs1    = 5'd0;
   logic [4:0] id_rs2    = 5'd0;
   logic [4:0] id_rd     = 5'd0;
   logic       flush     = 1'b0;

   logic       stall_n2, sel_a_n2, sel_b_n2;
   logic [1:0] fwd1_n2, fwd2_n2;
   logic       stall_n3, sel_a_n3, sel_b_n3;
   logic [1:0] fwd1_n3, fwd2_n3;

   always #5 clk = ~clk;

   forward_scoreboard #(.NUM_STAGES(2), .READY_STAGE(2), .RF_BYPASS(0)) dut_n2 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(stall_n2), .fwd_sel_rs1(fwd1_n2), .fwd_sel_rs2(fwd2_n2),
      .sel_a(sel_a_n2), .sel_b(sel_b_n2)
   );

   forward_scoreboard #(.NUM_STAGES(3), .READY_STAGE(2), .RF_BYPASS(1)) dut_n3 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
      .stall(stall_n3), .fwd_sel_rs1(fwd1_n3), .fwd_sel_rs2(fwd2_n3),
      .sel_a(sel_a_n3), .sel_b(sel_b_n3)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model: issue history by cycle ----------------
   localparam int MAXC = 1024;
   typedef struct packed {
      logic       v;
      logic [6:0] opc;
      logic [4:0] rd;
   } rec_t;

   rec_t hist [2][MAXC];
   int   cyc        = 0;
   int   valid_from = 0;
   logic pend [2]   = '{1'b0, 1'b0};

   function automatic logic m_writes(input logic [6:0] opc, input logic [4:0] rd);
      return (rd != 5'd0) && (opc != OPC_STORE) && (opc != OPC_BRANCH);
   endfunction

   function automatic logic m_late(input logic [6:0] opc);
      return (opc == OPC_LOAD) || (opc == OPC_SYSTEM);
   endfunction

   function automatic logic m_uses1(input logic [6:0] opc);
      return !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
   endfunction

   function automatic logic m_uses2(input logic [6:0] opc);
      return (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   endfunction

   // Youngest earlier-issued writer of r still in the pipe (age 1..n) decides.
   function automatic void m_operand(input int which, input logic used, input logic [4:0] r,
                                     output int sel, output logic blk);
      int   n;
      logic byp;
      int   c;
      rec_t e;
      n   = (which == 0) ? 2 : 3;
      byp = (which == 1);
      sel = 0;
      blk = 1'b0;
      if (used && (r != 5'd0)) begin
         for (int a = 1; a <= n; a++) begin
            c = cyc - a;
            if (c >= 0 && c >= valid_from) begin
               e = hist[which][c];
               if (e.v && m_writes(e.opc, e.rd) && (e.rd == r)) begin
                  if (m_late(e.opc) && (a < 2)) blk = 1'b1;
                  else if (byp && (a == n)) sel = 0;
                  else sel = a;
                  break;
               end
            end
         end
      end
   endfunction

   // Per-cycle compare of both DUTs against the model.
   always @(negedge clk) begin
      if (!reset) begin
         for (int d = 0; d < 2; d++) begin
            int    s1, s2;
            logic  b1, b2, es;
            string tag;
            tag = (d == 0) ? "n2" : "n3";
            m_operand(d, m_uses1(id_opcode), id_rs1, s1, b1);
            m_operand(d, m_uses2(id_opcode), id_rs2, s2, b2);
            es = id_valid && !flush && (b1 || b2);
            check({"model_stall_", tag}, (d == 0) ? 32'(stall_n2) : 32'(stall_n3), 32'(es));
            check({"model_fwd1_", tag},  (d == 0) ? 32'(fwd1_n2)  : 32'(fwd1_n3),  32'(s1));
            check({"model_fwd2_", tag},  (d == 0) ? 32'(fwd2_n2)  : 32'(fwd2_n3),  32'(s2));
            check({"model_sel_a_", tag}, (d == 0) ? 32'(sel_a_n2) : 32'(sel_a_n3),
                  32'((id_opcode == OPC_AUIPC) || (id_opcode == OPC_JAL) || (id_opcode == OPC_BRANCH)));
            check({"model_sel_b_", tag}, (d == 0) ? 32'(sel_b_n2) : 32'(sel_b_n3),
                  32'(id_opcode != OPC_OP));
            pend[d] = id_valid && !flush && !es;
         end
      end else begin
         pend[0] = 1'b0;
         pend[1] = 1'b0;
      end
   end

   // Record what each DUT accepted into slot 1 at this edge.
   always @(posedge clk) begin
      if (cyc < MAXC) begin
         for (int d = 0; d < 2; d++) begin
            hist[d][cyc] = (!reset && pend[d]) ? {1'b1, id_opcode, id_rd} : '0;
         end
      end
      cyc++;
   end

   // Reset forgets everything issued before it.
   always @(posedge reset) valid_from = cyc;

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic [6:0] opc, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic fl,
                       input logic rst_pulse);
      @(posedge clk);
      #1;
      id_valid  = v;
      id_opcode = opc;
      id_rd     = rd;
      id_rs1    = rs1;
      id_rs2    = rs2;
      flush     = fl;
      if (rst_pulse) begin
         #1 reset = 1'b1;
         #1 reset = 1'b0;
      end
      @(negedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      // Reset state with a valid instruction in decode.
      id_valid = 1'b1; id_opcode = OPC_OP; id_rd = 5'd1; id_rs1 = 5'd1; id_rs2 = 5'd1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_stall_n2", 32'(stall_n2), 32'd0);
      check("reset_fwd1_n2",  32'(fwd1_n2),  32'd0);
      check("reset_fwd2_n2",  32'(fwd2_n2),  32'd0);
      check("reset_stall_n3", 32'(stall_n3), 32'd0);
      @(posedge clk);
      #1;
      reset    = 1'b0;
      id_valid = 1'b0;

      // 1: ALU result forwarded from slot 1, slot 2, then RF.
      step(1'b1, OPC_OP, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0);
      check("t1_sel_a_add", 32'(sel_a_n2), 32'd0);
      check("t1_sel_b_add", 32'(sel_b_n2), 32'd0);
      step(1'b1, OPC_OP, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0);
      check("t1_fwd1_slot1_n2", 32'(fwd1_n2),  32'd1);
      check("t1_stall_n2",      32'(stall_n2), 32'd0);
      check("t1_fwd1_slot1_n3", 32'(fwd1_n3),  32'd1);
      step(1'b1, OPC_OP, 5'd10, 5'd5, 5'd0, 1'b0, 1'b0);
      check("t1_fwd1_slot2_n2", 32'(fwd1_n2), 32'd2);
      check("t1_fwd1_slot2_n3", 32'(fwd1_n3), 32'd2);
      step(1'b1, OPC_OP, 5'd11, 5'd5, 5'd0, 1'b0, 1'b0);
      check("t1_fwd1_retired_n2", 32'(fwd1_n2), 32'd0);
      check("t1_fwd1_bypass_n3",  32'(fwd1_n3), 32'd0);

      // 2: load-use stall of exactly one cycle.
      step(1'b1, OPC_LOAD, 5'd7, 5'd1, 5'd0, 1'b0, 1'b0);
      step(1'b1, OPC_OP, 5'd8, 5'd7, 5'd7, 1'b0, 1'b0);
      check("t2_stall_n2", 32'(stall_n2), 32'd1);
      check("t2_fwd1_stalled_n2", 32'(fwd1_n2), 32'd0);
      step(1'b1, OPC_OP, 5'd8, 5'd7, 5'd7, 1'b0, 1'b0);
      check("t2_stall_released_n2", 32'(stall_n2), 32'd0);
      check("t2_fwd1_n2", 32'(fwd1_n2), 32'd2);
      check("t2_fwd2_n2", 32'(fwd2_n2), 32'd2);

      // 3: youngest writer wins; stores never write.
      step(1'b1, OPC_OP,    5'd9, 5'd1, 5'd2, 1'b0, 1'b0);
      step(1'b1, OPC_OPIMM, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0);
      check("t3_addi_fwd1", 32'(fwd1_n2), 32'd1);
      step(1'b1, OPC_STORE, 5'd9, 5'd9, 5'd9, 1'b0, 1'b0);
      check("t3_sw_fwd1",  32'(fwd1_n2),  32'd1);
      check("t3_sw_fwd2",  32'(fwd2_n2),  32'd1);
      check("t3_sw_sel_b", 32'(sel_b_n2), 32'd1);
      step(1'b1, OPC_OP, 5'd13, 5'd9, 5'd0, 1'b0, 1'b0);
      check("t3_after_sw_fwd1", 32'(fwd1_n2), 32'd2);

      // 4: x0 and unused operands.
      step(1'b1, OPC_OPIMM, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0);
      step(1'b1, OPC_OP, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
      check("t4_x0_fwd1",  32'(fwd1_n2),  32'd0);
      check("t4_x0_fwd2",  32'(fwd2_n2),  32'd0);
      check("t4_x0_stall", 32'(stall_n2), 32'd0);
      step(1'b1, OPC_OP, 5'd5, 5'd2, 5'd3, 1'b0, 1'b0);
      step(1'b1, OPC_LUI, 5'd14, 5'd5, 5'd0, 1'b0, 1'b0);
      check("t4_lui_fwd1", 32'(fwd1_n2), 32'd0);
      step(1'b1, OPC_AUIPC, 5'd15, 5'd5, 5'd5, 1'b0, 1'b0);
      check("t4_auipc_sel_a", 32'(sel_a_n2), 32'd1);
      check("t4_auipc_fwd1",  32'(fwd1_n2),  32'd0);
      step(1'b1, OPC_BRANCH, 5'd0, 5'd14, 5'd15, 1'b0, 1'b0);
      check("t4_br_fwd1",  32'(fwd1_n2),  32'd2);
      check("t4_br_fwd2",  32'(fwd2_n2),  32'd1);
      check("t4_br_sel_a", 32'(sel_a_n2), 32'd1);

      // 5: flush masks the stall and keeps the flushed instruction out of slot 1.
      step(1'b1, OPC_LOAD, 5'd3, 5'd1, 5'd0, 1'b0, 1'b0);
      step(1'b1, OPC_OP, 5'd4, 5'd3, 5'd1, 1'b1, 1'b0);
      check("t5_flush_stall", 32'(stall_n2), 32'd0);
      step(1'b1, OPC_OP, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0);
      check("t5_fwd1_slot2", 32'(fwd1_n2),  32'd2);
      check("t5_stall",      32'(stall_n2), 32'd0);
      step(1'b1, OPC_LOAD, 5'd16, 5'd1, 5'd0, 1'b1, 1'b0);
      step(1'b1, OPC_OP, 5'd17, 5'd16, 5'd0, 1'b0, 1'b0);
      check("t5_flushed_lw_stall", 32'(stall_n2), 32'd0);
      check("t5_flushed_lw_fwd1",  32'(fwd1_n2),  32'd0);

      // 6: reset between issue and use of a load.
      step(1'b1, OPC_LOAD, 5'd2, 5'd1, 5'd0, 1'b0, 1'b0);
      step(1'b1, OPC_OP, 5'd18, 5'd2, 5'd2, 1'b0, 1'b1);
      check("t6_stall_n2", 32'(stall_n2), 32'd0);
      check("t6_fwd1_n2",  32'(fwd1_n2),  32'd0);
      check("t6_stall_n3", 32'(stall_n3), 32'd0);
      step(1'b1, OPC_OP, 5'd19, 5'd2, 5'd2, 1'b0, 1'b0);
      check("t6_later_fwd1", 32'(fwd1_n2), 32'd0);
      check("t6_later_fwd2", 32'(fwd2_n2), 32'd0);

      step(1'b0, OPC_OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      step(1'b0, OPC_OP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
